// File: rtl/ili9341_spi_tx.sv
// ili9341_spi_tx
// -----------------------------------------------------------------------------
// Byte-level SPI serializer for the ILI9341 panel. {dc, byte} words enter a
// small FIFO and are shifted out MSB-first in SPI mode 0 (SCLK idle low, data
// sampled by the panel on SCLK rising edges). CS is held low across
// back-to-back bytes, so a stream of queued words forms one gapless frame.
//
// Handshake (valid/ready): a word is accepted on a rising sysclk edge where
// in_valid && in_ready. in_ready depends only on the registered FIFO count
// (never on in_valid), and once in_valid is raised the upstream keeps
// in_dc/in_data stable until the accepting edge. A push and a pop on the same
// edge are both honoured.
//
// Ports:
//   sysclk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake
//   in_dc, in_data         D/CX flag and byte of the word
//   busy                   FIFO non-empty or frame in progress
//   byte_done              1-cycle pulse at a byte's 8th SCLK falling edge
//   tft_cs/dc/clk/din      panel pins (CS active-low, SCLK idle low)
//   dbg_state              current FSM state (IDLE=0, LOW=1, HIGH=2, HOLD=3)
// -----------------------------------------------------------------------------
module ili9341_spi_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_dc,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic       byte_done,
    output logic       tft_cs,
    output logic       tft_dc,
    output logic       tft_clk,
    output logic       tft_din,
    output logic [1:0] dbg_state
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [AW:0]     L_DEPTH    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DW-1:0]   L_DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ---------------- input FIFO ----------------
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [8:0]    w_head;

    assign w_full   = (r_count == L_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];
    assign in_ready = !w_full;

    always_ff @(posedge sysclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_dc, in_data};
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- serializer ----------------
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_dc;
    logic          r_clk;
    logic          r_cs;
    logic          r_done;
    logic          w_div_end;
    logic          w_load;
    logic          w_shift;
    logic          w_last_fall;

    // Every non-IDLE state lasts exactly CLK_DIV cycles, so all of their
    // transitions happen on w_div_end.
    assign w_div_end = (r_div == L_DIV_LAST);

    // State register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (!w_empty) w_state_nxt = S_LOW;
            S_LOW:  if (w_div_end) w_state_nxt = S_HIGH;
            S_HIGH: begin
                if (w_div_end) begin
                    // More bits, or another queued word: stay in the frame.
                    if (r_bit_cnt != 3'd0 || !w_empty) w_state_nxt = S_LOW;
                    else                               w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: if (w_div_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_last_fall = 1'b0;
        unique case (r_state)
            S_IDLE: w_load = !w_empty;
            S_HIGH: begin
                if (w_div_end) begin
                    if (r_bit_cnt != 3'd0) begin
                        w_shift = 1'b1;
                    end else begin
                        w_last_fall = 1'b1;
                        // Gapless: the next word is popped on the same SCLK
                        // falling edge that ends the current byte.
                        w_load      = !w_empty;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign w_pop = w_load;

    // Pin registers. SCLK and CS are derived from the next state so the pins
    // come straight from flops; DC and DIN only change on loads/shifts, which
    // coincide with SCLK going (or staying) low.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_dc      <= 1'b0;
            r_clk     <= 1'b0;
            r_cs      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_div  <= (r_state == S_IDLE || w_div_end) ? '0 : r_div + 1'b1;
            r_clk  <= (w_state_nxt == S_HIGH);
            r_cs   <= (w_state_nxt == S_IDLE);
            r_done <= w_last_fall;
            if (w_load) begin
                r_shift   <= w_head[7:0];
                r_dc      <= w_head[8];
                r_bit_cnt <= 3'd7;
            end else if (w_shift) begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
        end
    end

    assign tft_cs    = r_cs;
    assign tft_dc    = r_dc;
    assign tft_clk   = r_clk;
    assign tft_din   = r_shift[7];
    assign byte_done = r_done;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Testbench for ili9341_spi_tx. Instance A uses CLK_DIV=2, instance B uses
// CLK_DIV=1; both use FIFO_DEPTH=4. A pin-level monitor rebuilds bytes from the
// SCLK rising edges and checks them against the queue of accepted words.
module tb_ili9341_spi_tx;

    localparam int  P     = 10;       // sysclk period
    localparam int  A_DIV = 2;
    localparam int  DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #(P/2) sysclk = ~sysclk;

    // ---------------- DUT A (CLK_DIV=2) ----------------
    logic       in_valid = 1'b0;
    logic       in_dc    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready, busy, byte_done, tft_cs, tft_dc, tft_clk, tft_din;
    logic [1:0] dbg_state;

    ili9341_spi_tx #(.CLK_DIV(A_DIV), .FIFO_DEPTH(DEPTH)) u_dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dc     (in_dc),
        .in_data   (in_data),
        .busy      (busy),
        .byte_done (byte_done),
        .tft_cs    (tft_cs),
        .tft_dc    (tft_dc),
        .tft_clk   (tft_clk),
        .tft_din   (tft_din),
        .dbg_state (dbg_state)
    );

    // ---------------- DUT B (CLK_DIV=1) ----------------
    logic       b_in_valid = 1'b0;
    logic       b_in_dc    = 1'b0;
    logic [7:0] b_in_data  = 8'h00;
    logic       b_in_ready, b_busy, b_byte_done, b_cs, b_dc, b_clk, b_din;
    logic [1:0] b_dbg_state;

    ili9341_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_dc     (b_in_dc),
        .in_data   (b_in_data),
        .busy      (b_busy),
        .byte_done (b_byte_done),
        .tft_cs    (b_cs),
        .tft_dc    (b_dc),
        .tft_clk   (b_clk),
        .tft_din   (b_din),
        .dbg_state (b_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- monitor for DUT A ----------------
    logic       prev_clk = 1'b0, prev_cs = 1'b1, prev_dc = 1'b0, prev_busy = 1'b0;
    logic [7:0] sh = 8'h00;
    logic       byte_dc = 1'b0;
    logic [8:0] last_rx = 9'h000;
    int         nbits = 0, bits_since_done = 0;
    int         rise_cnt = 0, done_cnt = 0, frames = 0, total_rises = 0;
    int         done_total = 0, bytes_rx = 0;
    longint     cs_fall_t = 0, cs_rise_t = 0, first_rise_t = 0, last_rise_t = 0;
    longint     last_fall_t = 0, busy_drop_t = 0, cs_high_gap = 0;
    longint     done_t[$];

    always @(negedge sysclk) begin
        if (!rst_n) begin
            nbits = 0; bits_since_done = 0;
            prev_clk = 1'b0; prev_cs = 1'b1; prev_dc = 1'b0; prev_busy = 1'b0;
        end else begin
            if (prev_cs && !tft_cs) begin
                frames++;
                cs_high_gap = $time - cs_rise_t;
                cs_fall_t = $time; rise_cnt = 0; done_cnt = 0; done_t.delete();
            end
            if (!prev_cs && tft_cs) cs_rise_t = $time;
            if (prev_busy && !busy) busy_drop_t = $time;
            if (tft_dc !== prev_dc) check("dc_change_while_clk_low", longint'(tft_clk), 0);
            if (prev_clk && !tft_clk) last_fall_t = $time;
            if (!prev_clk && tft_clk) begin
                check("cs_low_at_rise", longint'(tft_cs), 0);
                if (rise_cnt == 0) first_rise_t = $time;
                last_rise_t = $time; rise_cnt++; total_rises++;
                if (nbits == 0) byte_dc = tft_dc;
                else check("dc_stable_in_byte", longint'(tft_dc), longint'(byte_dc));
                sh = {sh[6:0], tft_din};
                nbits++; bits_since_done++;
                if (nbits == 8) begin
                    nbits = 0; bytes_rx++;
                    last_rx = {byte_dc, sh};
                    check("byte_was_expected", longint'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("rx_byte", longint'(last_rx), longint'(exp_q.pop_front()));
                end
            end
            if (byte_done) begin
                done_cnt++; done_total++;
                done_t.push_back($time);
                check("done_after_8_bits", bits_since_done, 8);
                check("done_on_last_fall", longint'(last_fall_t == $time), 1);
                bits_since_done = 0;
            end
            prev_clk = tft_clk; prev_cs = tft_cs; prev_dc = tft_dc; prev_busy = busy;
        end
    end

    // ---------------- monitor for DUT B ----------------
    logic        b_prev_clk = 1'b0, b_prev_cs_low = 1'b0;
    int          b_rises = 0, b_cs_low = 0, b_repeat = 0;
    logic [15:0] b_bits = 16'h0000;

    always @(negedge sysclk) begin
        if (rst_n) begin
            if (!b_cs) begin
                b_cs_low++;
                if (b_prev_cs_low && b_clk === b_prev_clk) b_repeat++;
            end
            if (!b_prev_clk && b_clk) begin
                b_rises++;
                b_bits = {b_bits[14:0], b_din};
            end
            b_prev_clk = b_clk; b_prev_cs_low = !b_cs;
        end
    end

    // ---------------- driver tasks ----------------
    longint acc_t = 0;
    int     push_idx = 0, stalls = 0, first_stall_idx = -1;

    task automatic push_word(input logic dc, input logic [7:0] d);
        int guard = 0;
        @(negedge sysclk);
        in_valid = 1'b1; in_dc = dc; in_data = d;
        while (!in_ready && guard < 500) begin
            if (guard == 0) begin
                stalls++;
                if (first_stall_idx < 0) first_stall_idx = push_idx;
            end
            @(negedge sysclk);
            guard++;
        end
        check("push_ready", longint'(in_ready), 1);
        @(posedge sysclk);
        acc_t = $time;
        exp_q.push_back({dc, d});
        push_idx++;
    endtask

    task automatic release_bus();
        @(negedge sysclk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge sysclk); #1;
            if (!busy && tft_cs) ok = 1'b1;
        end
        check(tag, longint'(ok), 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int f0, r0, n0, d0;
        bit seen;

        // Reset values
        repeat (3) @(negedge sysclk);
        #1;
        check("rst_cs",       longint'(tft_cs), 1);
        check("rst_clk",      longint'(tft_clk), 0);
        check("rst_din",      longint'(tft_din), 0);
        check("rst_dc",       longint'(tft_dc), 0);
        check("rst_busy",     longint'(busy), 0);
        check("rst_done",     longint'(byte_done), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_b_cs",     longint'(b_cs), 1);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        // 1: single command byte 0xA5
        f0 = frames; n0 = bytes_rx;
        push_word(1'b0, 8'hA5);
        release_bus();
        wait_idle(200, "t1_idle");
        check("t1_cs_fall_latency", cs_fall_t - acc_t, P + P/2);
        check("t1_rx_byte",         longint'(last_rx), 'h0A5);
        check("t1_rises",           rise_cnt, 8);
        check("t1_first_rise",      first_rise_t - cs_fall_t, A_DIV * P);
        check("t1_sclk_span",       last_rise_t - first_rise_t, 7 * 2 * A_DIV * P);
        check("t1_done_cnt",        done_cnt, 1);
        check("t1_cs_rise_delay",   cs_rise_t - last_fall_t, A_DIV * P);
        check("t1_busy_drop",       busy_drop_t, cs_rise_t);
        check("t1_frames",          frames - f0, 1);
        check("t1_bytes",           bytes_rx - n0, 1);

        // 2: command + two data bytes back-to-back in one frame
        f0 = frames; n0 = bytes_rx;
        push_word(1'b0, 8'h2C);
        push_word(1'b1, 8'h12);
        push_word(1'b1, 8'h34);
        release_bus();
        wait_idle(400, "t2_idle");
        check("t2_frames",    frames - f0, 1);
        check("t2_rises",     rise_cnt, 24);
        check("t2_done_cnt",  done_cnt, 3);
        if (done_t.size() == 3) begin
            check("t2_done_gap0", done_t[1] - done_t[0], 16 * A_DIV * P);
            check("t2_done_gap1", done_t[2] - done_t[1], 16 * A_DIV * P);
        end
        check("t2_bytes",     bytes_rx - n0, 3);
        check("t2_q_empty",   exp_q.size(), 0);

        // 3: six words with in_valid held; FIFO fills and back-pressures
        f0 = frames; n0 = bytes_rx;
        push_idx = 0; stalls = 0; first_stall_idx = -1;
        for (int i = 0; i < 6; i++) begin
            push_word(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        release_bus();
        wait_idle(800, "t3_idle");
        // First word leaves the FIFO one cycle after acceptance, so five
        // accepts fit before the count reaches the depth.
        check("t3_first_stall_idx", first_stall_idx, DEPTH + 1);
        check("t3_backpressure",    longint'(stalls > 0), 1);
        check("t3_bytes",           bytes_rx - n0, 6);
        check("t3_frames",          frames - f0, 1);
        check("t3_q_empty",         exp_q.size(), 0);

        // 4: second word arrives during HOLD -> separate frame
        f0 = frames; n0 = bytes_rx; d0 = done_total;
        push_word(1'b1, 8'h3C);
        release_bus();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge sysclk); #1;
            if (done_total > d0) seen = 1'b1;
        end
        check("t4_done_seen", longint'(seen), 1);
        push_word(1'b0, 8'hC3);   // accepted 2 cycles after byte_done
        release_bus();
        wait_idle(200, "t4_idle");
        check("t4_frames",     frames - f0, 2);
        check("t4_cs_gap",     cs_high_gap, P);
        check("t4_bytes",      bytes_rx - n0, 2);
        check("t4_rx_byte",    longint'(last_rx), 'h0C3);

        // 5: reset during bit 4 with two words queued
        push_word(1'b1, 8'h81);
        push_word(1'b1, 8'h42);
        push_word(1'b1, 8'h24);
        release_bus();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge sysclk); #1;
            if (rise_cnt >= 4) seen = 1'b1;
        end
        check("t5_reached_bit4", longint'(seen), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_cs",    longint'(tft_cs), 1);
        check("t5_rst_clk",   longint'(tft_clk), 0);
        check("t5_rst_din",   longint'(tft_din), 0);
        check("t5_rst_busy",  longint'(busy), 0);
        check("t5_rst_ready", longint'(in_ready), 1);
        exp_q.delete();
        repeat (2) @(negedge sysclk);
        #2 rst_n = 1'b1;
        r0 = total_rises; n0 = bytes_rx;
        repeat (40) @(negedge sysclk);
        #1;
        check("t5_no_sclk_after_rst", total_rises - r0, 0);
        check("t5_cs_idle",           longint'(tft_cs), 1);
        check("t5_busy_idle",         longint'(busy), 0);
        push_word(1'b0, 8'h5A);
        release_bus();
        wait_idle(200, "t5_idle");
        check("t5_bytes",   bytes_rx - n0, 1);
        check("t5_rx_byte", longint'(last_rx), 'h05A);

        // 6: CLK_DIV=1 instance, 0xFF then 0x00
        @(negedge sysclk); #1;
        b_rises = 0; b_cs_low = 0; b_repeat = 0; b_bits = 16'h0000;
        check("t6_b_ready0", longint'(b_in_ready), 1);
        b_in_valid = 1'b1; b_in_dc = 1'b1; b_in_data = 8'hFF;
        @(negedge sysclk);
        check("t6_b_ready1", longint'(b_in_ready), 1);
        b_in_data = 8'h00;
        @(negedge sysclk);
        b_in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge sysclk); #1;
            if (!b_busy && b_cs) seen = 1'b1;
        end
        check("t6_b_idle",     longint'(seen), 1);
        check("t6_b_rises",    b_rises, 16);
        check("t6_b_bits",     longint'(b_bits), 'hFF00);
        check("t6_b_cs_low",   b_cs_low, 16 * 2 + 1);
        check("t6_b_toggle",   b_repeat, 0);

        // 7: random words with random gaps
        n0 = bytes_rx;
        for (int i = 0; i < 12; i++) begin
            push_word(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) begin
                release_bus();
                repeat ($urandom_range(0, 40)) @(negedge sysclk);
            end
        end
        release_bus();
        wait_idle(2000, "t7_idle");
        check("t7_bytes",   bytes_rx - n0, 12);
        check("t7_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(P * 50000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
